// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, key width and key-schedule FSM states.
package aes_pkg;

  localparam int AES128_KEY_W = 128;

  typedef enum logic {IDLE, EMIT} state_t;

  // Entry 0 sits in the top byte, so entry b lives at bit offset 8*(255-b).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h00;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes128_key_round.sv
// One AES-128 key-expansion round, purely combinational.
// Byte i of a key is key[i*8 +: 8]; word j holds bytes 4j..4j+3 with byte 4j in the low bits.
module aes128_key_round
  import aes_pkg::*;
(
  input  logic [AES128_KEY_W-1:0] key_in,
  input  logic [7:0]              rcon,
  output logic [AES128_KEY_W-1:0] key_out
);

  logic [31:0] t;
  logic [31:0] w0_n, w1_n, w2_n, w3_n;

  // SubWord(RotWord(w3)): bytes 13,14,15,12 land in positions 0..3; rcon hits byte 0.
  assign t[7:0]   = sub_byte(key_in[111:104]) ^ rcon;
  assign t[15:8]  = sub_byte(key_in[119:112]);
  assign t[23:16] = sub_byte(key_in[127:120]);
  assign t[31:24] = sub_byte(key_in[103:96]);

  assign w0_n = key_in[31:0]   ^ t;
  assign w1_n = key_in[63:32]  ^ w0_n;
  assign w2_n = key_in[95:64]  ^ w1_n;
  assign w3_n = key_in[127:96] ^ w2_n;

  assign key_out = {w3_n, w2_n, w1_n, w0_n};

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: pops a cipher key, pushes round keys 0..NUM_ROUNDS in order,
// stalls on output full and pops the next key in the last-key cycle for zero-bubble operation.
module aes128_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AES128_KEY_W-1:0] in_key,
  output logic                    in_key_rd,
  input  logic                    in_key_empty,
  output logic [AES128_KEY_W-1:0] out_key,
  output logic                    out_key_wr,
  input  logic                    out_key_full,
  output logic                    busy,
  output logic [3:0]              round_idx
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_t                  state, state_nxt;
  logic [AES128_KEY_W-1:0] key_reg, key_nxt, round_key;
  logic [3:0]              rnd, rnd_nxt;
  logic [7:0]              rcon;
  logic                    pop, push;

  assign rcon = rcon_of(rnd + 4'd1);

  aes128_key_round u_round (
    .key_in  (key_reg),
    .rcon    (rcon),
    .key_out (round_key)
  );

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    rnd_nxt   = rnd;
    pop       = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        pop = !in_key_empty;
        if (!in_key_empty) begin
          key_nxt   = in_key;
          rnd_nxt   = 4'd0;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        push = !out_key_full;
        if (!out_key_full) begin
          if (rnd < LAST_RND) begin
            key_nxt = round_key;
            rnd_nxt = rnd + 4'd1;
          end else begin
            // Last key leaves this cycle, so the next key may be taken in the same edge.
            pop = !in_key_empty;
            if (!in_key_empty) begin
              key_nxt = in_key;
              rnd_nxt = 4'd0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      key_reg <= '0;
      rnd     <= 4'd0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      rnd     <= rnd_nxt;
    end
  end

  assign in_key_rd  = pop  && !reset;
  assign out_key_wr = push && !reset;
  assign out_key    = key_reg;
  assign round_idx  = rnd;
  assign busy       = (state == EMIT);

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Directed bench for the AES-128 key-schedule sequencer with a queue-based scoreboard.
module tb_aes128_key_sched_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] in_key;
  logic         in_key_rd;
  logic         in_key_empty;
  logic [127:0] out_key;
  logic         out_key_wr;
  logic         out_key_full;
  logic         busy;
  logic [3:0]   round_idx;

  aes128_key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_key       (in_key),
    .in_key_rd    (in_key_rd),
    .in_key_empty (in_key_empty),
    .out_key      (out_key),
    .out_key_wr   (out_key_wr),
    .out_key_full (out_key_full),
    .busy         (busy),
    .round_idx    (round_idx)
  );

  always #5 clock = ~clock;

  // Round keys written in FIPS-197 byte order (byte 0 first).
  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] fifo[$];
  int           push_cyc[$];
  int           pop_cyc[$];
  int           checks = 0;
  int           failures = 0;
  int           push_cnt = 0;
  int           pop_cnt = 0;
  int           cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] fb(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = x[(15-i)*8 +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Queue a key into the input FIFO and its 11 round keys into the scoreboard.
  task automatic issue(input bit zero_key);
    fifo.push_back(zero_key ? '0 : fb(FIPS_RK[0]));
    for (int i = 0; i < 11; i++)
      sb.push_back('{zero_key ? fb(ZERO_RK[i]) : fb(FIPS_RK[i]), 4'(i)});
  endtask

  task automatic wait_pushes(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (push_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (push_cnt < target) timeout(name);
  endtask

  task automatic wait_round(input logic [3:0] idx, input bit need_wr, input string name);
    int  n;
    bit  hit;
    n   = 0;
    hit = 0;
    while (!hit && n < 60) begin
      @(negedge clock);
      n++;
      hit = busy && (round_idx == idx) && (!need_wr || out_key_wr);
    end
    if (!hit) timeout(name);
  endtask

  // Input FIFO model: decide the pop from the mid-cycle request, apply it after the edge.
  initial begin
    logic rd_s;
    int   c_s;
    in_key       = '0;
    in_key_empty = 1'b1;
    forever begin
      @(negedge clock);
      rd_s = in_key_rd;
      c_s  = cyc;
      @(posedge clock);
      #1;
      if (rd_s && !reset && fifo.size() > 0) begin
        void'(fifo.pop_front());
        pop_cnt++;
        pop_cyc.push_back(c_s);
      end
      in_key       = (fifo.size() > 0) ? fifo[0] : '0;
      in_key_empty = (fifo.size() == 0);
    end
  end

  // Scoreboard monitor: every push is matched against the oldest expected round key.
  always @(negedge clock) begin
    if (!reset && out_key_wr) begin
      push_cnt++;
      push_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_push", {124'h0, round_idx}, 128'hffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("push_key", out_key, e.key);
        check("push_idx", {124'h0, round_idx}, {124'h0, e.idx});
      end
    end
  end

  initial begin
    int p0, q0, n0, m0;
    reset        = 1'b1;
    out_key_full = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    check("rst_out_key", out_key, '0);
    check("rst_round_idx", {124'h0, round_idx}, '0);
    check("rst_busy", {127'h0, busy}, '0);
    check("rst_rd", {127'h0, in_key_rd}, '0);
    check("rst_wr", {127'h0, out_key_wr}, '0);
    @(negedge clock);
    reset = 1'b0;

    // Empty input FIFO: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("idle_ctl", {125'h0, busy, in_key_rd, out_key_wr}, '0);
      check("idle_key", out_key, '0);
    end

    // FIPS key, no backpressure.
    p0 = push_cnt; q0 = pop_cnt; n0 = push_cyc.size(); m0 = pop_cyc.size();
    issue(0);
    wait_pushes(p0 + 11, 60, "fips_pushes");
    repeat (3) @(negedge clock);
    check("fips_pops", 128'(pop_cnt - q0), 128'd1);
    if (push_cyc.size() >= n0 + 11 && pop_cyc.size() > m0) begin
      check("fips_contig", 128'(push_cyc[n0+10] - push_cyc[n0]), 128'd10);
      check("fips_latency", 128'(push_cyc[n0] - pop_cyc[m0]), 128'd1);
    end
    check("fips_sb_empty", 128'(sb.size()), 128'd0);

    // Backpressure for 3 cycles on round key 4.
    p0 = push_cnt;
    issue(0);
    wait_round(4'd3, 1'b1, "bp_reach_r3");
    @(posedge clock);
    #1 out_key_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_wr", {127'h0, out_key_wr}, '0);
      check("bp_idx", {124'h0, round_idx}, 128'd4);
      check("bp_key", out_key, fb(FIPS_RK[4]));
    end
    @(posedge clock);
    #1 out_key_full = 1'b0;
    wait_pushes(p0 + 11, 60, "bp_pushes");
    repeat (3) @(negedge clock);
    check("bp_push_count", 128'(push_cnt - p0), 128'd11);
    check("bp_sb_empty", 128'(sb.size()), 128'd0);

    // Two keys back to back: FIPS then all-zero.
    p0 = push_cnt; q0 = pop_cnt; n0 = push_cyc.size(); m0 = pop_cyc.size();
    issue(0);
    issue(1);
    wait_pushes(p0 + 22, 90, "b2b_pushes");
    repeat (3) @(negedge clock);
    check("b2b_pops", 128'(pop_cnt - q0), 128'd2);
    if (push_cyc.size() >= n0 + 22 && pop_cyc.size() >= m0 + 2) begin
      check("b2b_contig", 128'(push_cyc[n0+21] - push_cyc[n0]), 128'd21);
      check("b2b_second_pop", 128'(pop_cyc[m0+1]), 128'(push_cyc[n0+10]));
    end

    // Reset in the middle of a cycle while round key 5 is presented.
    issue(0);
    wait_round(4'd5, 1'b0, "rst_reach_r5");
    #2 reset = 1'b1;
    #1;
    check("midrst_key", out_key, '0);
    check("midrst_idx", {124'h0, round_idx}, '0);
    check("midrst_busy", {127'h0, busy}, '0);
    check("midrst_wr", {127'h0, out_key_wr}, '0);
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    check("midrst_hold_key", out_key, '0);
    reset = 1'b0;
    p0 = push_cnt;
    issue(0);
    wait_pushes(p0 + 11, 60, "post_rst_pushes");
    repeat (3) @(negedge clock);
    check("post_rst_sb_empty", 128'(sb.size()), 128'd0);

    // Output full while keys are waiting: one pop, then a stall with no further pops.
    @(posedge clock);
    #1 out_key_full = 1'b1;
    p0 = push_cnt; q0 = pop_cnt;
    issue(0);
    issue(1);
    begin
      int n;
      n = 0;
      while (pop_cnt == q0 && n < 20) begin
        @(negedge clock);
        n++;
      end
      if (pop_cnt == q0) timeout("stall_first_pop");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stall_pops", 128'(pop_cnt - q0), 128'd1);
      check("stall_ctl", {125'h0, busy, in_key_rd, out_key_wr}, 128'b100);
      check("stall_key", out_key, fb(FIPS_RK[0]));
    end
    @(posedge clock);
    #1 out_key_full = 1'b0;
    wait_pushes(p0 + 22, 90, "stall_pushes");
    repeat (3) @(negedge clock);
    check("stall_total_pops", 128'(pop_cnt - q0), 128'd2);
    check("final_sb_empty", 128'(sb.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
